// File: rtl/demux8_dispatch_ctrl.sv
// Packet dispatcher: steers a single valid/ready stream into a one-entry slot feeding
// one of eight channels; packets addressed to disabled channels are consumed and counted.
module demux8_dispatch_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cfg_en,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_dest,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic [2:0]       cur_sel,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cur_sel;
  logic [2:0]       r_slot_sel;
  logic             r_slot_v;
  logic [7:0]       r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_out_last;
  logic [CNT_W-1:0] r_fwd_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_in_ready;
  logic w_accept;
  logic w_load;
  logic w_drain;
  logic w_fwd_done;
  logic w_drop_done;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Input acceptance per state; the slot may be refilled in the cycle it drains.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_FWD:  w_in_ready = !r_slot_v || out_ready[r_cur_sel];
      ST_DROP: w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept    = in_valid && w_in_ready;
  assign w_load      = w_accept && (r_state == ST_FWD);
  assign w_drain     = r_slot_v && out_ready[r_slot_sel];
  assign w_fwd_done  = w_load && in_last;
  assign w_drop_done = w_accept && (r_state == ST_DROP) && in_last;

  // Packet FSM: destination and enable are decided once, in IDLE, with the slot empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur_sel <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && !r_slot_v) begin
            r_cur_sel <= in_dest;
            if (cfg_en[in_dest]) begin
              r_state <= ST_FWD;
            end else begin
              r_state <= ST_DROP;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FWD: begin
          if (w_fwd_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FWD;
          end
        end
        ST_DROP: begin
          if (w_drop_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DROP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output slot: load wins over drain so back-to-back beats flow at one per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_v    <= 1'b0;
      r_slot_sel  <= 3'd0;
      r_out_valid <= 8'd0;
      r_out_data  <= {DW{1'b0}};
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_slot_v    <= 1'b1;
      r_slot_sel  <= r_cur_sel;
      r_out_valid <= 8'd1 << r_cur_sel;
      r_out_data  <= in_data;
      r_out_last  <= in_last;
    end else if (w_drain) begin
      r_slot_v    <= 1'b0;
      r_out_valid <= 8'd0;
    end else begin
      r_slot_v    <= r_slot_v;
      r_out_valid <= r_out_valid;
    end
  end

  // Statistics: clear takes priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_fwd_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_fwd_done) begin
        r_fwd_cnt <= sat_inc(r_fwd_cnt);
      end else begin
        r_fwd_cnt <= r_fwd_cnt;
      end
      if (w_drop_done) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE) || r_slot_v;
  assign cur_sel   = r_cur_sel;
  assign fwd_cnt   = r_fwd_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
